alu_try: RTL and testbench
==========================

// Module: alu_try
// PURPOSE
//   16-bit, 8-function integer ALU for the CORG processor datapath.
//   Combinationally evaluates operation on a/b; registers result and flags on clk.
//   Sits between the register-file read ports and the writeback/branch logic.
//   Flags (zero/carry/overflow) feed branch resolution.
// PARAMETERS
//   WIDTH   16   operand/result width; only 16 is verified
//   SHW     4    shift-amount width (log2 WIDTH); low SHW bits of b used as shamt
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands/operation valid this cycle
//   operation  in   3      function select (see BEHAVIOUR)
//   a          in   16     operand A
//   b          in   16     operand B (shift amount in b[3:0] for SLL/SRL)
//   out_valid  out  1      result/flags valid (registered)
//   result     out  16     registered result
//   zero       out  1      registered: result == 16'h0000
//   carry      out  1      registered: ADD carry-out / SUB no-borrow (a>=b unsigned); 0 otherwise
//   overflow   out  1      registered: signed overflow for ADD/SUB; 0 otherwise
// BEHAVIOUR
//   Clocking/reset: one clock; reset is asynchronous and active-low.
//   - rst_n=0 forces immediately: result=0, zero=1, carry=0, overflow=0, out_valid=0.
//   - Reset asserted mid-operation discards the in-flight result; first valid output
//     after release requires a fresh in_valid.
//   Latency: exactly 1 cycle. Inputs sampled on rising edge with in_valid=1 appear on
//     outputs right after that edge; out_valid=1 for that one cycle.
//   in_valid=0: out_valid<=0; result/zero/carry/overflow HOLD previous values.
//   No backpressure; a new operation may be issued every cycle (full throughput).
//   Operation encoding (all arithmetic modulo 2^16):
//     000 ADD  a+b; carry=bit16 of 17-bit sum; overflow=(a[15]==b[15])&&(r[15]!=a[15])
//     001 AND  a&b
//     010 SUB  a-b (a + ~b + 1); carry=1 iff a>=b unsigned;
//              overflow=(a[15]!=b[15])&&(r[15]!=a[15])
//     011 OR   a|b
//     100 XOR  a^b
//     101 SLL  a << b[3:0], zero-fill; b[15:4] ignored
//     110 SLT  signed compare: result=16'h0001 if $signed(a)<$signed(b), else 16'h0000
//     111 SRL  a >> b[3:0], logical, zero-fill; b[15:4] ignored
//   zero computed from the new result for every operation, including SLT.
//   carry/overflow forced 0 for all non-ADD/SUB operations.
//   Shift by 0 returns a unchanged; shift by 15 keeps only one bit.
//   No X propagation: every operation code defined; outputs never X after reset.
//   Fully synchronous datapath besides async reset; no latches, no combinational outputs.
// TESTING
//   ADD: a=16'h5555 b=16'h3333 -> result=16'h8888 zero=0 carry=0 overflow=1
//   AND/OR/XOR: a=16'h5555 b=16'hAAAA -> AND 16'h0000 zero=1; OR 16'hFFFF; XOR 16'hFFFF
//   SUB: a=16'h9999 b=16'h3333 -> result=16'h6666 carry=1 overflow=1;
//        a=0 b=1 -> 16'hFFFF carry=0 overflow=0
//   SLL/SRL: a=16'h5555 b=16'h0003 -> SLL 16'hAAA8; SRL 16'h0AAA;
//        b=16'hFFF0 -> result=16'h5555 (shamt 0)
//   SLT: a=16'h5555 b=16'hAAAA -> 16'h0000 zero=1;
//        a=16'hAAAA b=16'h5555 -> 16'h0001 zero=0
//   Control: back-to-back in_valid every cycle -> one result per cycle, 1-cycle latency;
//        in_valid=0 holds result; rst_n low mid-stream -> outputs clear without clk edge

Source files
------------

// File: rtl/alu_try.sv
// rtl/alu_try.sv - 16-bit 8-function registered integer ALU with zero/carry/overflow flags
module alu_try #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    // Both adders carry one extra bit so carry-out / no-borrow falls out of the top bit.
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [SHW-1:0]   shamt;
    logic             slt_bit;

    logic [WIDTH-1:0] nxt_result;
    logic             nxt_carry;
    logic             nxt_overflow;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt    = b[SHW-1:0];
    assign slt_bit  = ($signed(a) < $signed(b));

    // Combinational function select; flags are cleared for every non-arithmetic op.
    always_comb begin
        nxt_result   = '0;
        nxt_carry    = 1'b0;
        nxt_overflow = 1'b0;
        case (operation)
            OP_ADD: begin
                nxt_result   = add_full[WIDTH-1:0];
                nxt_carry    = add_full[WIDTH];
                nxt_overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                               (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: nxt_result = a & b;
            OP_SUB: begin
                nxt_result   = sub_full[WIDTH-1:0];
                nxt_carry    = sub_full[WIDTH];
                nxt_overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                               (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  nxt_result = a | b;
            OP_XOR: nxt_result = a ^ b;
            OP_SLL: nxt_result = a << shamt;
            OP_SLT: nxt_result = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SRL: nxt_result = a >> shamt;
            default: nxt_result = '0;
        endcase
    end

    // Output register: capture on in_valid, otherwise hold the last result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= nxt_result;
                zero     <= (nxt_result == '0);
                carry    <= nxt_carry;
                overflow <= nxt_overflow;
            end
        end
    end

endmodule

// File: tb/tb_alu_try.sv
// tb/tb_alu_try.sv - self-checking bench for alu_try: vector table, corner sequences, random vs model
module tb_alu_try;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  operation;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [15:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_r;
    logic        exp_z, exp_c, exp_v;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[19];

    alu_try dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic [15:0] r,
                              input logic z, input logic c, input logic v);
        check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, ov});
        check({tag, " result"},    {16'b0, result},    {16'b0, r});
        check({tag, " zero"},      {31'b0, zero},      {31'b0, z});
        check({tag, " carry"},     {31'b0, carry},     {31'b0, c});
        check({tag, " overflow"},  {31'b0, overflow},  {31'b0, v});
    endtask

    // Reference model from the arithmetic definitions, using wide signed/unsigned ints.
    task automatic model(input logic [2:0] op, input logic [15:0] ia, input logic [15:0] ib,
                         output logic [15:0] r, output logic c, output logic v);
        int ua, ub, sa, sb, t, sh;
        ua = int'(ia);
        ub = int'(ib);
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        sh = ub % 16;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd0: begin
                t = ua + ub;
                r = t[15:0];
                c = (t > 65535);
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            3'd1: r = ia & ib;
            3'd2: begin
                t = ua - ub;
                r = t[15:0];
                c = (ua >= ub);
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: begin
                t = ua * (1 << sh);
                r = t[15:0];
            end
            3'd6: r = (sa < sb) ? 16'd1 : 16'd0;
            default: begin
                t = ua / (1 << sh);
                r = t[15:0];
            end
        endcase
    endtask

    task automatic drive(input logic iv, input logic [2:0] op, input logic [15:0] ia,
                         input logic [15:0] ib);
        @(negedge clk);
        in_valid  = iv;
        operation = op;
        a         = ia;
        b         = ib;
    endtask

    initial begin
        logic [15:0] mr;
        logic        mc, mv, iv;
        logic [2:0]  rop;
        logic [15:0] ra, rb;

        vecs[0]  = '{3'd0, 16'h5555, 16'h3333, 16'h8888, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3'd1, 16'h5555, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'd3, 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd4, 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd2, 16'h9999, 16'h3333, 16'h6666, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{3'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd5, 16'h5555, 16'h0003, 16'hAAA8, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd7, 16'h5555, 16'h0003, 16'h0AAA, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd5, 16'h5555, 16'hFFF0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd7, 16'h5555, 16'hFFF0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'd6, 16'h5555, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'd6, 16'hAAAA, 16'h5555, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{3'd2, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{3'd5, 16'h5555, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'd7, 16'h5555, 16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{3'd6, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{3'd2, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operation = 3'd0;
        a         = 16'h0;
        b         = 16'h0;

        #7;
        check_outs("reset", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table applied back-to-back: one result per cycle, visible right after the edge.
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), 1'b1, vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].v);
        end

        // Hold: in_valid low keeps the previous result and flags while inputs change.
        drive(1'b1, 3'd2, 16'h9999, 16'h3333);
        @(posedge clk);
        #1;
        check_outs("hold_src", 1'b1, 16'h6666, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 3'd1, 16'h0000, 16'h0000);
            @(posedge clk);
            #1;
            check_outs($sformatf("hold%0d", i), 1'b0, 16'h6666, 1'b0, 1'b1, 1'b1);
        end

        // Asynchronous reset mid-stream: outputs clear between clock edges.
        drive(1'b1, 3'd0, 16'h5555, 16'h3333);
        @(posedge clk);
        #1;
        check_outs("pre_rst", 1'b1, 16'h8888, 1'b0, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("rst_held", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 16'h5555, 16'h3333);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("post_rst", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Random traffic against the model, with holds interleaved.
        exp_r = 16'h0000;
        exp_z = 1'b1;
        exp_c = 1'b0;
        exp_v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            iv  = ($urandom_range(0, 3) != 0);
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            drive(iv, rop, ra, rb);
            @(posedge clk);
            #1;
            if (iv) begin
                model(rop, ra, rb, mr, mc, mv);
                exp_r = mr;
                exp_z = (mr == 16'h0000);
                exp_c = mc;
                exp_v = mv;
            end
            check_outs($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb),
                       iv, exp_r, exp_z, exp_c, exp_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
